// File: rtl/fc_dense_layer.sv
// fc_dense_layer: fully-connected stage behind the conv/pool front end.
// It holds one pooled feature map and a row-major weight matrix, then computes
// N_OUT neurons with a single multiply-accumulate per cycle. Each neuron result
// is shifted by FRAC, saturated to 16 bits and streamed out in neuron order.
// Optional build macro: FC_RELU_EN clamps negative saturated results to zero.
module fc_dense_layer #(
  parameter int N_IN   = 49,
  parameter int N_OUT  = 10,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_load,
  input  logic signed [COEF_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] pool_in,
  input  logic                     pool_valid,
  output logic                     pool_ready,
  output logic signed [DATA_W-1:0] fc_out,
  output logic [7:0]               fc_idx,
  output logic                     fc_valid,
  output logic                     fc_done,
  output logic                     busy
);

  localparam int N_W    = N_IN * N_OUT;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int FA_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OA_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WA_W   = (N_W   > 1) ? $clog2(N_W)   : 1;

  localparam logic [FA_W-1:0] I_LAST = FA_W'(N_IN - 1);
  localparam logic [OA_W-1:0] O_LAST = OA_W'(N_OUT - 1);
  localparam logic [WA_W-1:0] W_LAST = WA_W'(N_W - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WLOAD   = 2'd1,
    S_FILL    = 2'd2,
    S_COMPUTE = 2'd3
  } state_t;

  // Arithmetic shift (rounds toward -inf) followed by two-sided clamp.
  function automatic logic signed [DATA_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end
    return s[DATA_W-1:0];
  endfunction

  // Final output mapping; the activation is applied after saturation.
  function automatic logic signed [DATA_W-1:0] out_map(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [DATA_W-1:0] r;
    r = sat_shift(a);
`ifdef FC_RELU_EN
    if (r[DATA_W-1]) begin
      r = '0;
    end
`else
    r = r;
`endif
    return r;
  endfunction

  // Storage: not reset, only meaningful after a complete load/fill.
  logic signed [COEF_W-1:0] w_mem [N_W];
  logic signed [DATA_W-1:0] f_mem [N_IN];

  state_t                   state_q,      state_d;
  logic [FA_W-1:0]          i_q,          i_d;
  logic [OA_W-1:0]          o_q,          o_d;
  logic [WA_W-1:0]          wptr_q,       wptr_d;
  logic signed [ACC_W-1:0]  acc_q,        acc_d;
  logic                     drain_q,      drain_d;
  logic                     weights_ok_q, weights_ok_d;
  logic signed [DATA_W-1:0] fc_out_q,     fc_out_d;
  logic [7:0]               fc_idx_q,     fc_idx_d;
  logic                     fc_valid_q,   fc_valid_d;
  logic                     fc_done_q,    fc_done_d;

  logic                     w_we;
  logic                     f_we;
  logic signed [DATA_W-1:0] f_rd;
  logic signed [COEF_W-1:0] w_rd;
  logic signed [PROD_W-1:0] f_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_base;

  // Feature index doubles as fill address and MAC feature index; the weight
  // pointer doubles as load address and MAC weight index (o*N_IN+i).
  assign f_rd     = f_mem[i_q];
  assign w_rd     = w_mem[wptr_q];
  assign f_ext    = {{COEF_W{f_rd[DATA_W-1]}}, f_rd};
  assign w_ext    = {{DATA_W{w_rd[COEF_W-1]}}, w_rd};
  assign prod     = f_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // The first term of each neuron starts from zero, so the previous neuron's
  // sum can be emitted in the very same cycle.
  assign acc_base = (i_q == '0) ? '0 : acc_q;

  // Next-state, counters, accumulator and output strobes.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    o_d          = o_q;
    wptr_d       = wptr_q;
    acc_d        = acc_q;
    drain_d      = drain_q;
    weights_ok_d = weights_ok_q;
    fc_out_d     = fc_out_q;
    fc_idx_d     = fc_idx_q;
    fc_valid_d   = 1'b0;
    fc_done_d    = 1'b0;
    w_we         = 1'b0;
    f_we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_load) begin
          state_d      = S_WLOAD;
          weights_ok_d = 1'b0;
          wptr_d       = '0;
        end else if (pool_valid && weights_ok_q) begin
          f_we = 1'b1;
          if (N_IN == 1) begin
            state_d = S_COMPUTE;
            i_d     = '0;
            wptr_d  = '0;
          end else begin
            state_d = S_FILL;
            i_d     = i_q + 1'b1;
          end
        end
      end
      S_WLOAD: begin
        w_we = 1'b1;
        if (wptr_q == W_LAST) begin
          weights_ok_d = 1'b1;
          state_d      = S_IDLE;
          wptr_d       = '0;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      S_FILL: begin
        if (pool_valid) begin
          f_we = 1'b1;
          if (i_q == I_LAST) begin
            state_d = S_COMPUTE;
            i_d     = '0;
            wptr_d  = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (drain_q) begin
          // Last neuron's sum is complete: emit it and finish the image.
          fc_valid_d = 1'b1;
          fc_done_d  = 1'b1;
          fc_idx_d   = 8'(N_OUT - 1);
          fc_out_d   = out_map(acc_q);
          state_d    = S_IDLE;
          drain_d    = 1'b0;
          acc_d      = '0;
          i_d        = '0;
          o_d        = '0;
          wptr_d     = '0;
        end else begin
          if ((i_q == '0) && (o_q != '0)) begin
            fc_valid_d = 1'b1;
            fc_idx_d   = 8'(o_q) - 8'd1;
            fc_out_d   = out_map(acc_q);
          end
          acc_d = acc_base + prod_ext;
          if (i_q == I_LAST) begin
            i_d = '0;
            if (o_q == O_LAST) begin
              drain_d = 1'b1;
              wptr_d  = '0;
            end else begin
              o_d    = o_q + 1'b1;
              wptr_d = wptr_q + 1'b1;
            end
          end else begin
            i_d    = i_q + 1'b1;
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, accumulator and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      o_q          <= '0;
      wptr_q       <= '0;
      acc_q        <= '0;
      drain_q      <= 1'b0;
      weights_ok_q <= 1'b0;
      fc_out_q     <= '0;
      fc_idx_q     <= '0;
      fc_valid_q   <= 1'b0;
      fc_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      o_q          <= o_d;
      wptr_q       <= wptr_d;
      acc_q        <= acc_d;
      drain_q      <= drain_d;
      weights_ok_q <= weights_ok_d;
      fc_out_q     <= fc_out_d;
      fc_idx_q     <= fc_idx_d;
      fc_valid_q   <= fc_valid_d;
      fc_done_q    <= fc_done_d;
    end
  end

  // Weight and feature RAM writes.
  always_ff @(posedge clk) begin
    if (w_we) begin
      w_mem[wptr_q] <= w_in;
    end
    if (f_we) begin
      f_mem[i_q] <= pool_in;
    end
  end

  assign pool_ready = weights_ok_q && ((state_q == S_IDLE) || (state_q == S_FILL));
  assign busy       = (state_q == S_WLOAD) || (state_q == S_COMPUTE);
  assign fc_out     = fc_out_q;
  assign fc_idx     = fc_idx_q;
  assign fc_valid   = fc_valid_q;
  assign fc_done    = fc_done_q;

endmodule

// File: tb/tb_fc_dense_layer.sv
// Self-checking bench for fc_dense_layer (N_IN=4, N_OUT=2, FRAC=8).
module tb_fc_dense_layer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int NW    = N_IN * N_OUT;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               w_load = 1'b0;
  logic signed [15:0] w_in = '0;
  logic signed [15:0] pool_in = '0;
  logic               pool_valid = 1'b0;
  logic               pool_ready;
  logic signed [15:0] fc_out;
  logic [7:0]         fc_idx;
  logic               fc_valid;
  logic               fc_done;
  logic               busy;

  fc_dense_layer #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .FRAC (8),
    .ACC_W(40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_load    (w_load),
    .w_in      (w_in),
    .pool_in   (pool_in),
    .pool_valid(pool_valid),
    .pool_ready(pool_ready),
    .fc_out    (fc_out),
    .fc_idx    (fc_idx),
    .fc_valid  (fc_valid),
    .fc_done   (fc_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  idx;
    logic [15:0] val;
    logic        vld;
    logic        done;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  ev_t         evq[$];
  logic [15:0] wts   [NW];
  logic [15:0] feats [N_IN];
  logic [15:0] expv  [N_OUT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product in plain integers, then >>>8, clamp, optional ReLU.
  function automatic logic [15:0] ref_neuron(input int o);
    longint s;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      s += longint'($signed(feats[i])) * longint'($signed(wts[o*N_IN+i]));
    end
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic load_weights();
    @(negedge clk);
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    w_in   = wts[0];
    check("busy_in_wload", {31'd0, busy}, 32'd1);
    for (int k = 1; k < NW; k++) begin
      @(negedge clk);
      w_in = wts[k];
    end
    @(negedge clk);
    w_in = '0;
    check("after_wload_busy_ready", {30'd0, busy, pool_ready}, 32'd1);
  endtask

  task automatic send_features(input int gap, input logic exp_ready);
    check("ready_before_fill", {31'd0, pool_ready}, {31'd0, exp_ready});
    for (int i = 0; i < N_IN; i++) begin
      repeat (gap) @(negedge clk);
      pool_valid = 1'b1;
      pool_in    = feats[i];
      @(negedge clk);
      pool_valid = 1'b0;
    end
  endtask

  task automatic collect(input int ncyc, input bit disturb);
    evq.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (disturb && c == 2) begin
        w_load     = 1'b1;
        pool_valid = 1'b1;
        pool_in    = 16'h1234;
      end else if (disturb && c == 3) begin
        w_load     = 1'b0;
        pool_valid = 1'b0;
        check("compute_busy_notready", {30'd0, busy, pool_ready}, 32'd2);
      end
      if (fc_valid || fc_done) begin
        evq.push_back('{cyc: c, idx: fc_idx, val: fc_out, vld: fc_valid, done: fc_done});
      end
    end
  endtask

  task automatic run_image(input string tag, input int gap, input bit disturb);
    for (int o = 0; o < N_OUT; o++) expv[o] = ref_neuron(o);
    send_features(gap, 1'b1);
    collect(14, disturb);
    check($sformatf("%s_event_count", tag), evq.size(), N_OUT);
    for (int k = 0; k < evq.size() && k < N_OUT; k++) begin
      check($sformatf("%s_cycle%0d", tag, k), evq[k].cyc, N_IN + 1 + k * N_IN);
      check($sformatf("%s_valid%0d", tag, k), {31'd0, evq[k].vld}, 32'd1);
      check($sformatf("%s_idx%0d", tag, k), {24'd0, evq[k].idx}, k);
      check($sformatf("%s_out%0d", tag, k), {16'd0, evq[k].val}, {16'd0, expv[k]});
      check($sformatf("%s_done%0d", tag, k), {31'd0, evq[k].done},
            (k == N_OUT - 1) ? 32'd1 : 32'd0);
    end
    check($sformatf("%s_idle_after", tag), {30'd0, busy, pool_ready}, 32'd1);
  endtask

  task automatic set_case2();
    for (int k = 0; k < NW; k++) wts[k] = 16'h0100;
    for (int i = 0; i < N_IN; i++) feats[i] = 16'((i + 1) * 256);
  endtask

  initial begin
    // Reset with pool_valid asserted.
    rst_n      = 1'b0;
    pool_valid = 1'b1;
    pool_in    = 16'h7777;
    repeat (3) @(negedge clk);
    check("rst_fc_out", {16'd0, fc_out}, 32'd0);
    check("rst_fc_idx", {24'd0, fc_idx}, 32'd0);
    check("rst_strobes", {28'd0, fc_valid, fc_done, busy, pool_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_weights_ignored", {29'd0, fc_valid, busy, pool_ready}, 32'd0);
    pool_valid = 1'b0;
    @(negedge clk);

    // Unit weights, ramp features.
    set_case2();
    load_weights();
    run_image("case2", 0, 1'b0);
    check("case2_value0", {16'd0, expv[0]}, 32'h0A00);

    // Positive saturation.
    for (int k = 0; k < NW; k++) wts[k] = 16'h7FFF;
    for (int i = 0; i < N_IN; i++) feats[i] = 16'h7FFF;
    load_weights();
    run_image("case3", 0, 1'b0);

    // Negative neuron.
    for (int k = 0; k < NW; k++) wts[k] = (k < N_IN) ? 16'h0100 : 16'hFF00;
    for (int i = 0; i < N_IN; i++) feats[i] = 16'h0100;
    load_weights();
    run_image("case4", 0, 1'b0);

    // Gapped features, disturbances during compute.
    set_case2();
    load_weights();
    run_image("case5", 3, 1'b1);

    // Randomized images.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NW; k++) wts[k] = 16'($urandom);
      for (int i = 0; i < N_IN; i++) feats[i] = 16'($urandom);
      load_weights();
      run_image($sformatf("rand%0d", n), $urandom_range(0, 2), 1'b0);
    end

    // Reset mid-compute.
    set_case2();
    load_weights();
    send_features(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {28'd0, fc_valid, fc_done, busy, pool_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_features(0, 1'b0);
    collect(14, 1'b0);
    check("midrst_no_events", evq.size(), 0);
    check("midrst_idle", {30'd0, busy, pool_ready}, 32'd0);
    load_weights();
    run_image("case6", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
